// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
//
// Pops raw bytes from a UART RX FIFO (standard non-FWFT read port) and hunts
// for frames of the form HDR0, HDR1, LEN, LEN payload bytes, CHK, where CHK is
// (LEN + sum of payload bytes) mod 256. Payload bytes are streamed out on a
// valid/ready interface as they arrive, tagged with start/end of frame. The
// verdict arrives afterwards on frame_done_o/frame_ok_o/err_code_o, so the
// consumer drops a frame whose verdict is bad.
//
// Optional build macro: FRAME_TIMEOUT_EN
//   When defined, an inter-byte idle counter aborts a partially received frame
//   after TIMEOUT_CYCLES clocks without a byte (err_code_o = 3). When not
//   defined, the parser waits indefinitely and TIMEOUT_CYCLES is ignored.
//
// Ports:
//   sys_clk_i        single clock for all logic
//   rst_i            asynchronous, active-high reset
//   fifo_rd_en_o     read strobe to the RX FIFO
//   fifo_dout_i      FIFO data, valid the cycle after fifo_rd_en_o
//   fifo_empty_i     FIFO empty flag
//   m_data_o         payload byte
//   m_valid_o        payload byte valid
//   m_ready_i        downstream accepts the payload byte
//   m_sof_o          first payload byte of a frame (qualified by m_valid_o)
//   m_eof_o          last payload byte of a frame (qualified by m_valid_o)
//   frame_done_o     one-cycle pulse when a frame ends (good or bad)
//   frame_ok_o       verdict, valid while frame_done_o is high
//   err_code_o       0 ok, 1 checksum, 2 length, 3 timeout; held until next verdict
//   frame_ok_cnt_o   good frame counter, wraps
//   frame_err_cnt_o  bad frame counter, wraps
module uart_rx_frame_parser #(
  parameter logic [7:0]  HDR0           = 8'h55,
  parameter logic [7:0]  HDR1           = 8'hAA,
  parameter logic [7:0]  MAX_LEN        = 8'd64,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  output logic        fifo_rd_en_o,
  input  logic [7:0]  fifo_dout_i,
  input  logic        fifo_empty_i,
  output logic [7:0]  m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_sof_o,
  output logic        m_eof_o,
  output logic        frame_done_o,
  output logic        frame_ok_o,
  output logic [1:0]  err_code_o,
  output logic [15:0] frame_ok_cnt_o,
  output logic [15:0] frame_err_cnt_o
);

  typedef enum logic [2:0] {
    ST_HUNT0   = 3'd0,
    ST_HUNT1   = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_t      state_q, state_d;
  state_t      byte_state;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_sof_q, m_sof_d;
  logic        m_eof_q, m_eof_d;
  logic        first_q, first_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  sum_q, sum_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        byte_vld;
  logic        timeout_hit;

  // One read in flight at most; no new read while a payload byte is held so
  // the verdict for CHK can never overtake the last payload byte.
  assign fifo_rd_en_o = !rst_i && !fifo_empty_i && !rd_pend_q && !m_valid_q;
  // Non-FWFT FIFO: data presented the cycle after the read strobe.
  assign byte_vld     = rd_pend_q;

`ifdef FRAME_TIMEOUT_EN
  logic [19:0] idle_q, idle_d;

  // idle_q counts clocks since the last captured byte; it reads TIMEOUT-1 on
  // the cycle before the abort is registered, so frame_done_o rises exactly
  // TIMEOUT_CYCLES clocks after the last byte's capture edge.
  always_comb begin
    timeout_hit = (state_q != ST_HUNT0) && (idle_q == TIMEOUT_CYCLES - 20'd1);
    if (byte_vld || (state_q == ST_HUNT0)) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 20'd1;
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    rd_pend_d    = fifo_rd_en_o;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_sof_d      = m_sof_q;
    m_eof_d      = m_eof_q;
    first_d      = first_q;
    rem_d        = rem_q;
    sum_d        = sum_q;
    frame_done_d = 1'b0;
    frame_ok_d   = 1'b0;
    err_code_d   = err_code_q;
    ok_cnt_d     = ok_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_sof_d   = 1'b0;
      m_eof_d   = 1'b0;
    end

    // A timeout drops back to HUNT0 and a byte arriving on the same cycle is
    // parsed as if already in HUNT0.
    byte_state = timeout_hit ? ST_HUNT0 : state_q;

    if (timeout_hit) begin
      state_d      = ST_HUNT0;
      frame_done_d = 1'b1;
      frame_ok_d   = 1'b0;
      err_code_d   = ERR_TIMEOUT;
      err_cnt_d    = err_cnt_q + 16'd1;
    end

    if (byte_vld) begin
      case (byte_state)
        ST_HUNT0: begin
          state_d = (fifo_dout_i == HDR0) ? ST_HUNT1 : ST_HUNT0;
        end
        ST_HUNT1: begin
          if (fifo_dout_i == HDR1) begin
            state_d = ST_LEN;
          end else if (fifo_dout_i == HDR0) begin
            state_d = ST_HUNT1;
          end else begin
            state_d = ST_HUNT0;
          end
        end
        ST_LEN: begin
          if ((fifo_dout_i == 8'd0) || (fifo_dout_i > MAX_LEN)) begin
            state_d      = ST_HUNT0;
            frame_done_d = 1'b1;
            frame_ok_d   = 1'b0;
            err_code_d   = ERR_LEN;
            err_cnt_d    = err_cnt_q + 16'd1;
          end else begin
            state_d = ST_PAYLOAD;
            rem_d   = fifo_dout_i;
            sum_d   = fifo_dout_i;
            first_d = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          m_valid_d = 1'b1;
          m_data_d  = fifo_dout_i;
          m_sof_d   = first_q;
          m_eof_d   = (rem_q == 8'd1);
          first_d   = 1'b0;
          sum_d     = sum_q + fifo_dout_i;
          rem_d     = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          state_d      = ST_HUNT0;
          frame_done_d = 1'b1;
          if (fifo_dout_i == sum_q) begin
            frame_ok_d = 1'b1;
            err_code_d = ERR_OK;
            ok_cnt_d   = ok_cnt_q + 16'd1;
          end else begin
            frame_ok_d = 1'b0;
            err_code_d = ERR_CHK;
            err_cnt_d  = err_cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_HUNT0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_HUNT0;
      rd_pend_q    <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_sof_q      <= 1'b0;
      m_eof_q      <= 1'b0;
      first_q      <= 1'b0;
      rem_q        <= '0;
      sum_q        <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_code_q   <= ERR_OK;
      ok_cnt_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_pend_q    <= rd_pend_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_sof_q      <= m_sof_d;
      m_eof_q      <= m_eof_d;
      first_q      <= first_d;
      rem_q        <= rem_d;
      sum_q        <= sum_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_code_q   <= err_code_d;
      ok_cnt_q     <= ok_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign m_data_o        = m_data_q;
  assign m_valid_o       = m_valid_q;
  assign m_sof_o         = m_sof_q;
  assign m_eof_o         = m_eof_q;
  assign frame_done_o    = frame_done_q;
  assign frame_ok_o      = frame_ok_q;
  assign err_code_o      = err_code_q;
  assign frame_ok_cnt_o  = ok_cnt_q;
  assign frame_err_cnt_o = err_cnt_q;

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Sits directly downstream of the per-channel UART receive FIFO read port (8-bit, standard non-FWFT FIFO, same clock domain as the reader).
- Pops raw received bytes and hunts for frames of the form 0x55, 0xAA, LEN, LEN payload bytes, CHK.
- Streams payload bytes out with a valid/ready handshake, marking the first and last bytes.
- Reports a per-frame good/bad verdict and keeps good and bad frame counters.

Parameters:
- HDR0, 8'h55, first sync byte.
- HDR1, 8'hAA, second sync byte.
- MAX_LEN, 64, largest legal LEN value (1..255).
- TIMEOUT_CYCLES, 20'd500000, inter-byte timeout in sys_clk_i cycles; used only with FRAME_TIMEOUT_EN.

Ports:
- sys_clk_i  in  1  single clock for all logic.
- rst_i  in  1  asynchronous, active-high reset.
- fifo_rd_en_o  out  1  read strobe to the RX FIFO.
- fifo_dout_i  in  8  FIFO data; valid the cycle after fifo_rd_en_o.
- fifo_empty_i  in  1  FIFO empty flag.
- m_data_o  out  8  payload byte.
- m_valid_o  out  1  payload byte valid.
- m_ready_i  in  1  downstream accepts the byte.
- m_sof_o  out  1  first payload byte of a frame; qualified by m_valid_o.
- m_eof_o  out  1  last payload byte of a frame; qualified by m_valid_o.
- frame_done_o  out  1  one-cycle pulse when a frame ends (good or bad).
- frame_ok_o  out  1  verdict, valid while frame_done_o is high.
- err_code_o  out  2  verdict detail: 0 ok, 1 checksum, 2 length, 3 timeout; held until the next frame_done_o.
- frame_ok_cnt_o  out  16  good frames, wraps at 16'hFFFF.
- frame_err_cnt_o  out  16  bad frames, wraps at 16'hFFFF.

Behaviour:
- Reset: all outputs 0, FSM in HUNT0, counters 0, any pending read discarded.
- Read engine:
  - fifo_rd_en_o is high for one cycle when !fifo_empty_i && !rd_pend && !m_valid_o.
  - rd_pend is set on that cycle.
  - On the next cycle the byte is captured and rd_pend clears.
  - So there is at most one read in flight, and the minimum spacing is 2 cycles per byte.
  - No read is issued while a payload byte is waiting on m_ready_i.
- FSM, advanced once per captured byte:
  - HUNT0: byte == HDR0 -> HUNT1; otherwise stay.
  - HUNT1: byte == HDR1 -> LEN; byte == HDR0 -> stay in HUNT1; otherwise -> HUNT0.
  - LEN:
    - LEN == 0 or LEN > MAX_LEN: frame_done_o pulse, frame_ok_o = 0, err_code_o = 2, frame_err_cnt_o + 1, -> HUNT0.
    - Otherwise: load the remaining-byte counter, set sum = LEN, -> PAYLOAD.
  - PAYLOAD:
    - Each byte drives m_data_o and sets m_valid_o the cycle after capture.
    - m_sof_o is high on the first byte; m_eof_o is high when the remaining count is 1.
    - sum = sum + byte, mod 256.
    - After the last byte -> CHK.
  - CHK:
    - Byte == sum: frame_ok_o = 1, err_code_o = 0, frame_ok_cnt_o + 1.
    - Otherwise: frame_ok_o = 0, err_code_o = 1, frame_err_cnt_o + 1.
    - Either way: frame_done_o pulse, -> HUNT0.
- Output handshake:
  - m_valid_o, m_data_o, m_sof_o and m_eof_o are held stable until m_valid_o && m_ready_i, then cleared the following cycle.
  - m_ready_i may be high before m_valid_o rises.
- Payload is forwarded before the checksum is known. The downstream consumer discards a frame whose frame_done_o arrives with frame_ok_o = 0.
- A LEN = 1 frame produces m_sof_o and m_eof_o together on the same byte.
- A bad header byte never produces frame_done_o and never changes either counter.
- frame_done_o for the CHK byte fires no earlier than the acceptance of the m_eof_o byte, because no read is issued while the last byte is pending.
- Counters wrap from 16'hFFFF to 0.

Optional Feature:
- FRAME_TIMEOUT_EN defined:
  - A 20-bit idle counter clears on every captured byte and while the FSM is in HUNT0.
  - It increments every cycle in any other state.
  - On reaching TIMEOUT_CYCLES: frame_done_o pulse, frame_ok_o = 0, err_code_o = 3, frame_err_cnt_o + 1, FSM -> HUNT0.
  - A byte captured on the same cycle as the timeout is treated as the first byte in HUNT0.
  - A timeout in PAYLOAD leaves any held m_valid_o byte to complete its handshake normally.
- FRAME_TIMEOUT_EN not defined: no timeout counter; the FSM waits indefinitely; err_code_o never takes the value 3.

Test Plan:
- Good frame: FIFO holds 55 AA 03 11 22 33 69, m_ready_i = 1.
  - Expect payload 11 (sof), 22, 33 (eof).
  - Expect frame_done_o with frame_ok_o = 1, err_code_o = 0, frame_ok_cnt_o = 1.
- Bad checksum: FIFO holds 55 AA 02 10 20 00.
  - Expect payload 10 (sof), 20 (eof).
  - Expect frame_done_o with frame_ok_o = 0, err_code_o = 1, frame_err_cnt_o = 1.
- Resync and length error: FIFO holds 00 55 55 AA 00, then 55 AA 41 with MAX_LEN = 64.
  - Expect two frame_done_o pulses, both err_code_o = 2, no m_valid_o, frame_err_cnt_o = 2.
- Backpressure: good frame 55 AA 01 7E 7F with m_ready_i held low for 20 cycles.
  - Expect m_valid_o = 1 with 7E stable for the full 20 cycles.
  - Expect fifo_rd_en_o = 0 throughout; frame_done_o (ok) only after m_ready_i rises.
- Timeout (FRAME_TIMEOUT_EN, TIMEOUT_CYCLES = 100): FIFO holds 55 AA 04 01, then stays empty.
  - Expect frame_done_o exactly 100 cycles after the 01 byte capture, err_code_o = 3.
  - Then 55 AA 01 05 06 parses ok.
- Async reset: assert rst_i mid-PAYLOAD.
  - Expect all outputs 0 immediately.
  - After release, the next good frame parses ok with frame_ok_cnt_o = 1.
